unsaved_mem_test_master: RTL
============================

# unsaved_mem_test_master

Avalon-MM master that drives the single-port on-chip memory slave (32-bit data, 16-bit word address, fixed read latency) from the other end of the bus. On `start` it fills a word range with a deterministic pattern, reads the range back, and compares each word, reporting pass/fail, an error count and the first failing address. It sits beside the on-chip RAM as a built-in self-test and bring-up initiator, sharing the RAM's clock domain.

## Interface
- `ADDR_W`, 16, word-address width, equal to the memory's address width.
- `DEPTH`, 32896, number of implemented memory words.
- `READ_LATENCY`, 1, cycles from address presented to `avm_readdata` valid (1..4).

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `start_addr` in ADDR_W: first word address.
- `word_count` in ADDR_W+1: number of words; 0 is legal.
- `seed` in 32: pattern seed (used only with the LFSR build).
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of a run.
- `pass` out 1: run result; valid from `done`, held until the next accepted `start`.
- `range_err` out 1: run rejected, range exceeds DEPTH.
- `error_count` out 16: mismatches, saturating at 16'hFFFF.
- `first_err_addr` out ADDR_W: address of first mismatch; 0 if none.
- `avm_address` out ADDR_W, `avm_byteenable` out 4 (always 4'hF while active), `avm_chipselect` out 1, `avm_write` out 1, `avm_writedata` out 32, `avm_clken` out 1 (constant 1), `avm_readdata` in 32.

## Operation
- States: IDLE, FILL, READ, DRAIN, DONE.
- IDLE: bus idle (`avm_chipselect`=0, `avm_write`=0). On `start`: if `start_addr + word_count > DEPTH` (computed at ADDR_W+2 bits, no wrap) go to DONE with `range_err`=1, `pass`=0, no bus traffic; else if `word_count`=0 go to DONE with `pass`=1; else clear `error_count`, `first_err_addr`, `range_err` and go to FILL.
- FILL: one write per cycle, `avm_chipselect`=`avm_write`=1, addresses `start_addr` .. `start_addr+N-1`, data = pattern(i). After word N-1 go to READ.
- READ: one read per cycle, `avm_chipselect`=1, `avm_write`=0, same address sequence; pattern generator restarted from its initial state. Expected data and address are delayed READ_LATENCY cycles in a shift register and compared with `avm_readdata`. After last issue go to DRAIN.
- DRAIN: bus idle, READ_LATENCY cycles, remaining comparisons complete.
- DONE: `done`=1 for one cycle, `pass` = (`error_count`==0) unless `range_err`; return to IDLE.
- Mismatch: `error_count` increments (saturating); first mismatch of the run latches `first_err_addr`.
- `start` in any state other than IDLE is ignored; no abort input.
- Reset mid-run: all state returns to IDLE and bus deasserts on the same edge; no partial result reported.
- Reset values: `busy`, `done`, `pass`, `range_err`, `avm_chipselect`, `avm_write` = 0; `error_count`, `first_err_addr`, `avm_address`, `avm_writedata` = 0; `avm_byteenable`=4'hF; `avm_clken`=1.

## Timing
- `start` accepted at edge k: first write in cycle k+1, writes k+1..k+N, reads k+N+1..k+2N, `done` in cycle k+2N+READ_LATENCY+1.
- `word_count`=0 or range error: `done` in cycle k+1, `busy` never asserts.
- Throughput: one word per cycle each phase; no waitrequest (slave never stalls).
- Next `start` accepted at earliest the cycle after `done`.

## Configuration
- `MEM_TEST_LFSR_EN` defined: pattern(i) is a 32-bit Galois LFSR, taps 32'h80200003, initial state `seed` (0 replaced by 32'h1), advanced once per word.
- Not defined: pattern(i) = {~addr, addr} with addr the 16-bit word address; `seed` unused.

## Test plan
- `start_addr`=0, `word_count`=4, clean memory -> writes 32'hFFFF0000, 32'hFFFE0001, 32'hFFFD0002, 32'hFFFC0003; `done` at k+10 (L=1), `pass`=1, `error_count`=0.
- Same run with model forcing readdata of address 2 to 0 -> `pass`=0, `error_count`=1, `first_err_addr`=2.
- `start_addr`=32890, `word_count`=7 -> `done` at k+1, `range_err`=1, `pass`=0, no chipselect; `start_addr`=32889, `word_count`=7 -> normal run, `pass`=1.
- `word_count`=0 -> `done` at k+1, `pass`=1, `busy` stays 0; `start` pulsed during FILL of a 16-word run -> ignored, single `done`.
- `reset` asserted mid-READ -> next cycle all outputs at reset values, bus idle; fresh run afterwards passes.
- LFSR build, `seed`=0, `word_count`=3 -> first write 32'h1, `pass`=1; READ_LATENCY=3 run of 8 words -> `done` at k+20.

Source files
------------

// File: rtl/unsaved_mem_test_master.sv
// Avalon-MM self-test master: fills a word range with a pattern, reads it back and compares.
// Build macro MEM_TEST_LFSR_EN swaps the {~addr, addr} pattern for a seeded 32-bit Galois LFSR.
module unsaved_mem_test_master #(
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 32896,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              range_err,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata
);
    localparam int L = READ_LATENCY;
    localparam logic [ADDR_W+1:0] DEPTH_C = (ADDR_W+2)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d, first_err_q, first_err_d;
    logic [31:0]         wdata_q, wdata_d, init_pat_q, init_pat_d;
    logic                cs_q, cs_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic                pass_q, pass_d, range_err_q, range_err_d, err_seen_q, err_seen_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W:0]     left_q, left_d, cnt_q, cnt_d;
    logic [2:0]          drain_q, drain_d;
    logic                exp_vld_q  [0:L];
    logic                exp_vld_d  [0:L];
    logic [31:0]         exp_data_q [0:L];
    logic [31:0]         exp_data_d [0:L];
    logic [ADDR_W-1:0]   exp_addr_q [0:L];
    logic [ADDR_W-1:0]   exp_addr_d [0:L];
    logic [ADDR_W+1:0]   range_sum_s;
    logic [31:0]         start_pat_s, adv_pat_s;

    assign range_sum_s = {2'b00, start_addr} + {1'b0, word_count};

`ifdef MEM_TEST_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // The current word's pattern lives in wdata during FILL and in the newest expect slot during READ.
    assign start_pat_s = (seed == 32'h0) ? 32'h1 : seed;
    assign adv_pat_s   = lfsr_next((state_q == S_FILL) ? wdata_q : exp_data_q[0]);
`else
    function automatic logic [31:0] addr_pattern(input logic [ADDR_W-1:0] a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {~a16, a16};
    endfunction

    logic seed_unused_s;
    assign seed_unused_s = ^seed;
    assign start_pat_s   = addr_pattern(start_addr);
    assign adv_pat_s     = addr_pattern(addr_q + ADDR_W'(1));
`endif

    // Next-state, bus and result computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        range_err_d = range_err_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        left_d      = left_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        init_pat_d  = init_pat_q;
        drain_d     = drain_q;
        exp_vld_d[0]  = 1'b0;
        exp_data_d[0] = exp_data_q[0];
        exp_addr_d[0] = exp_addr_q[0];
        for (int i = 1; i <= L; i++) begin
            exp_vld_d[i]  = exp_vld_q[i-1];
            exp_data_d[i] = exp_data_q[i-1];
            exp_addr_d[i] = exp_addr_q[i-1];
        end

        if (exp_vld_q[L] && (avm_readdata != exp_data_q[L])) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (!err_seen_q) begin
                first_err_d = exp_addr_q[L];
                err_seen_d  = 1'b1;
            end else begin
                first_err_d = first_err_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (range_sum_s > DEPTH_C) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    range_err_d = 1'b1;
                    pass_d      = 1'b0;
                end else if (word_count == (ADDR_W+1)'(0)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    range_err_d = 1'b0;
                    pass_d      = 1'b1;
                end else begin
                    state_d     = S_FILL;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    range_err_d = 1'b0;
                    err_cnt_d   = 16'd0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                    cs_d        = 1'b1;
                    we_d        = 1'b1;
                    addr_d      = start_addr;
                    wdata_d     = start_pat_s;
                    init_pat_d  = start_pat_s;
                    base_d      = start_addr;
                    cnt_d       = word_count;
                    left_d      = word_count - (ADDR_W+1)'(1);
                end
            end
            S_FILL: begin
                cs_d = 1'b1;
                if (left_q == (ADDR_W+1)'(0)) begin
                    // Restart the address and pattern sequence for the read-back pass.
                    state_d       = S_READ;
                    addr_d        = base_q;
                    left_d        = cnt_q - (ADDR_W+1)'(1);
                    exp_vld_d[0]  = 1'b1;
                    exp_data_d[0] = init_pat_q;
                    exp_addr_d[0] = base_q;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    wdata_d = adv_pat_s;
                    left_d  = left_q - (ADDR_W+1)'(1);
                end
            end
            S_READ: begin
                if (left_q == (ADDR_W+1)'(0)) begin
                    state_d = S_DRAIN;
                    drain_d = 3'(L - 1);
                end else begin
                    cs_d          = 1'b1;
                    addr_d        = addr_q + ADDR_W'(1);
                    left_d        = left_q - (ADDR_W+1)'(1);
                    exp_vld_d[0]  = 1'b1;
                    exp_data_d[0] = adv_pat_s;
                    exp_addr_d[0] = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    // The final comparison lands on this edge, so judge on the updated count.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = !range_err_q && (err_cnt_d == 16'd0);
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            range_err_q <= 1'b0;
            err_cnt_q   <= 16'd0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            left_q      <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            init_pat_q  <= 32'h0;
            drain_q     <= 3'd0;
            for (int i = 0; i <= L; i++) begin
                exp_vld_q[i]  <= 1'b0;
                exp_data_q[i] <= 32'h0;
                exp_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            range_err_q <= range_err_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            left_q      <= left_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            init_pat_q  <= init_pat_d;
            drain_q     <= drain_d;
            for (int i = 0; i <= L; i++) begin
                exp_vld_q[i]  <= exp_vld_d[i];
                exp_data_q[i] <= exp_data_d[i];
                exp_addr_q[i] <= exp_addr_d[i];
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign range_err      = range_err_q;
    assign error_count    = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = 4'hF;
    assign avm_chipselect = cs_q;
    assign avm_write      = we_q;
    assign avm_writedata  = wdata_q;
    assign avm_clken      = 1'b1;
endmodule
